apb_xbar_target_port: RTL and testbench
=======================================

// Module: apb_xbar_target_port
// PURPOSE
//  Completer-side port of the APB crossbar NoC, parametrised in requester count and widths.
//  Arbitrates NUM_REQ requesters contending for one completer using round-robin priority.
//  Drives one APB completer (SETUP/ACCESS) and returns the response to the granted requester.
//  Adds a pready watchdog that ends a hung transfer with an error response.
//  One instance per completer in the crossbar.
// PARAMETERS
//  NUM_REQ   3   number of requesters (>=2)
//  ADDR_W    60  address width ({28-bit high, 32-bit low} split)
//  DATA_W    32  data width
//  TIMEOUT   16  max ACCESS cycles without pready before forced error (>=2)
// PORTS
//  pclk        in   1                clock
//  preset      in   1                synchronous reset, active-high
//  req_valid   in   NUM_REQ          request pending; held until matching resp_valid
//  req_write   in   NUM_REQ          1=write 0=read, per requester
//  req_addr    in   NUM_REQ*ADDR_W   packed per-requester address, req i at [i*ADDR_W +: ADDR_W]
//  req_wdata   in   NUM_REQ*DATA_W   packed per-requester write data
//  resp_valid  out  NUM_REQ          one-cycle completion pulse to the served requester
//  resp_rdata  out  DATA_W           read data, valid with resp_valid
//  resp_err    out  1                pslverr or timeout, valid with resp_valid
//  busy        out  1                state != IDLE
//  psel        out  1                APB select
//  penable     out  1                APB enable
//  pwrite      out  1                APB direction
//  paddr       out  ADDR_W           APB address
//  pwdata      out  DATA_W           APB write data
//  prdata      in   DATA_W           APB read data
//  pready      in   1                APB ready
//  pslverr     in   1                APB error
// BEHAVIOUR
//  Reset:
//   - All outputs 0; state IDLE; timeout counter 0.
//   - last_grant = NUM_REQ-1, so requester 0 has top priority first.
//  FSM: IDLE -> SETUP -> ACCESS -> RESP -> IDLE.
//  IDLE:
//   - If any req_valid, grant the first set bit searching from last_grant+1, wrapping modulo NUM_REQ.
//   - Latch grant id, write, addr, wdata; update last_grant; go to SETUP.
//  SETUP: psel=1, penable=0; go to ACCESS.
//  ACCESS:
//   - psel=1, penable=1; count cycles.
//   - pready=1: capture prdata (reads; 0 for writes) and pslverr; go to RESP.
//   - Counter reaches TIMEOUT with pready still 0: rdata=0, err=1; go to RESP.
//  RESP:
//   - psel=penable=0; resp_valid[grant]=1 for exactly one cycle; go to IDLE.
//   - No arbitration in RESP. The requester drops or renews req_valid by the next edge.
//  pwrite/paddr/pwdata are registered from the latched request and stable across SETUP and ACCESS.
//  Latency:
//   - req_valid sampled at edge 0 gives psel at cycle 1 and penable at cycle 2.
//   - pready sampled at edge k gives resp_valid in cycle k+1.
//   - Minimum 4 cycles per transfer; no back-to-back ACCESS.
//  Edge cases:
//   - Simultaneous requests: only one granted; the others wait and are not dropped.
//   - req_valid deasserted mid-transfer: the transfer completes and resp_valid still pulses.
//   - Request fields change after grant: ignored (latched copy used).
//   - pready and timeout in the same cycle: pready wins, normal response.
//   - Reset mid-transfer: psel/penable/resp_valid 0 at the next edge; transfer discarded, no response.
//  Exactly one resp_valid bit at most is ever set.
// STRUCTURE
//  apb_xbar_pkg: state enum (IDLE, SETUP, ACCESS, RESP) and default width constants.
//  Sub-module rr_arbiter #(N): req vector + last_grant -> one-hot grant + index (combinational).
//  Counter width: $clog2(TIMEOUT+1).
// TESTING
//  Write from req0: addr 0x0123456789ABCDE, wdata 0xDEADBEEF, pready=1 immediately ->
//   psel at cycle 1, penable at cycle 2, resp_valid=3'b001 at cycle 3, err=0.
//  req_valid=3'b111 right after reset, every pready immediate -> served in order 0,1,2.
//   Then only req0 served, then 3'b011 asserted -> req1 granted first.
//  Read from req2, pready low 3 ACCESS cycles, prdata=0xCAFEF00D ->
//   paddr stable, resp_rdata=0xCAFEF00D, resp_valid=3'b100.
//  pready held 0 -> after 16 ACCESS cycles resp_err=1, resp_rdata=0; psel=0 the next cycle.
//  pslverr=1 with pready on a write from req1 -> resp_valid=3'b010, resp_err=1.
//  preset=1 during ACCESS -> psel=penable=0 next edge, no resp_valid; later 3'b111 grants req0.

Source files
------------

// File: rtl/apb_xbar_pkg.sv
// Shared types and default widths for the APB crossbar completer-side port.
package apb_xbar_pkg;

   typedef enum logic [1:0] {
      StIdle,
      StSetup,
      StAccess,
      StResp
   } state_e;

   localparam int unsigned DefNumReq  = 3;
   localparam int unsigned DefAddrW   = 60;
   localparam int unsigned DefDataW   = 32;
   localparam int unsigned DefTimeout = 16;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: searches upward from the requester after last_grant.
module rr_arbiter #(
   parameter int unsigned N    = 3,
   parameter int unsigned IdxW = $clog2(N)
) (
   input  logic [N-1:0]    req,
   input  logic [IdxW-1:0] last_grant,
   output logic [N-1:0]    grant,
   output logic [IdxW-1:0] grant_idx,
   output logic            any
);

   always_comb begin
      int unsigned j;
      grant     = '0;
      grant_idx = '0;
      any       = 1'b0;
      j         = 0;
      for (int unsigned i = 1; i <= N; i++) begin
         // last_grant never exceeds N-1, so one subtraction wraps correctly
         j = int'(last_grant) + i;
         if (j >= N) j = j - N;
         if (!any && req[j]) begin
            any       = 1'b1;
            grant_idx = IdxW'(j);
            grant[j]  = 1'b1;
         end
      end
   end

endmodule

// File: rtl/apb_xbar_target_port.sv
// Completer-side crossbar port: round-robin arbitration, APB SETUP/ACCESS sequencing,
// single-cycle response pulse and a pready watchdog.
module apb_xbar_target_port
   import apb_xbar_pkg::*;
#(
   parameter int unsigned NUM_REQ = DefNumReq,
   parameter int unsigned ADDR_W  = DefAddrW,
   parameter int unsigned DATA_W  = DefDataW,
   parameter int unsigned TIMEOUT = DefTimeout
) (
   input  logic                      pclk,
   input  logic                      preset,
   input  logic [NUM_REQ-1:0]        req_valid,
   input  logic [NUM_REQ-1:0]        req_write,
   input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
   input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
   output logic [NUM_REQ-1:0]        resp_valid,
   output logic [DATA_W-1:0]         resp_rdata,
   output logic                      resp_err,
   output logic                      busy,
   output logic                      psel,
   output logic                      penable,
   output logic                      pwrite,
   output logic [ADDR_W-1:0]         paddr,
   output logic [DATA_W-1:0]         pwdata,
   input  logic [DATA_W-1:0]         prdata,
   input  logic                      pready,
   input  logic                      pslverr
);

   localparam int unsigned IdxW = $clog2(NUM_REQ);
   localparam int unsigned CntW = $clog2(TIMEOUT + 1);

   state_e              state_q, state_d;
   logic [IdxW-1:0]     last_grant_q;
   logic [NUM_REQ-1:0]  grant_oh_q;
   logic                write_q;
   logic [ADDR_W-1:0]   addr_q;
   logic [DATA_W-1:0]   wdata_q;
   logic [DATA_W-1:0]   rdata_q;
   logic                err_q;
   logic [CntW-1:0]     cnt_q;

   logic [NUM_REQ-1:0]  arb_grant;
   logic [IdxW-1:0]     arb_idx;
   logic                arb_any;
   logic                timeout_hit;

   rr_arbiter #(
      .N    (NUM_REQ),
      .IdxW (IdxW)
   ) u_arb (
      .req        (req_valid),
      .last_grant (last_grant_q),
      .grant      (arb_grant),
      .grant_idx  (arb_idx),
      .any        (arb_any)
   );

   // Final ACCESS cycle allowed without pready
   assign timeout_hit = (cnt_q == CntW'(TIMEOUT - 1));

   always_ff @(posedge pclk) begin
      if (preset) state_q <= StIdle;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         StIdle:   if (arb_any) state_d = StSetup;
         StSetup:  state_d = StAccess;
         StAccess: if (pready || timeout_hit) state_d = StResp;
         StResp:   state_d = StIdle;
         default:  state_d = StIdle;
      endcase
   end

   always_comb begin
      psel       = 1'b0;
      penable    = 1'b0;
      resp_valid = '0;
      case (state_q)
         StSetup:  psel = 1'b1;
         StAccess: begin
            psel    = 1'b1;
            penable = 1'b1;
         end
         StResp:   resp_valid = grant_oh_q;
         default:  ;
      endcase
   end

   assign busy       = (state_q != StIdle);
   assign pwrite     = write_q;
   assign paddr      = addr_q;
   assign pwdata     = wdata_q;
   assign resp_rdata = rdata_q;
   assign resp_err   = err_q;

   always_ff @(posedge pclk) begin
      if (preset) begin
         last_grant_q <= IdxW'(NUM_REQ - 1);
         grant_oh_q   <= '0;
         write_q      <= 1'b0;
         addr_q       <= '0;
         wdata_q      <= '0;
         rdata_q      <= '0;
         err_q        <= 1'b0;
         cnt_q        <= '0;
      end else begin
         case (state_q)
            StIdle: begin
               cnt_q <= '0;
               if (arb_any) begin
                  last_grant_q <= arb_idx;
                  grant_oh_q   <= arb_grant;
                  write_q      <= req_write[arb_idx];
                  addr_q       <= req_addr[ADDR_W*arb_idx +: ADDR_W];
                  wdata_q      <= req_wdata[DATA_W*arb_idx +: DATA_W];
               end
            end
            StAccess: begin
               if (pready) begin
                  rdata_q <= write_q ? '0 : prdata;
                  err_q   <= pslverr;
               end else if (timeout_hit) begin
                  rdata_q <= '0;
                  err_q   <= 1'b1;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_apb_xbar_target_port.sv
// Directed self-checking bench for apb_xbar_target_port (3 requesters, 60-bit addr).
module tb_apb_xbar_target_port;

   localparam int unsigned NR = 3;
   localparam int unsigned AW = 60;
   localparam int unsigned DW = 32;
   localparam int unsigned TO = 16;

   logic              pclk;
   logic              preset;
   logic [NR-1:0]     req_valid;
   logic [NR-1:0]     req_write;
   logic [NR*AW-1:0]  req_addr;
   logic [NR*DW-1:0]  req_wdata;
   logic [NR-1:0]     resp_valid;
   logic [DW-1:0]     resp_rdata;
   logic              resp_err;
   logic              busy;
   logic              psel;
   logic              penable;
   logic              pwrite;
   logic [AW-1:0]     paddr;
   logic [DW-1:0]     pwdata;
   logic [DW-1:0]     prdata;
   logic              pready;
   logic              pslverr;

   int total;
   int bad;

   apb_xbar_target_port #(
      .NUM_REQ (NR),
      .ADDR_W  (AW),
      .DATA_W  (DW),
      .TIMEOUT (TO)
   ) dut (
      .pclk       (pclk),
      .preset     (preset),
      .req_valid  (req_valid),
      .req_write  (req_write),
      .req_addr   (req_addr),
      .req_wdata  (req_wdata),
      .resp_valid (resp_valid),
      .resp_rdata (resp_rdata),
      .resp_err   (resp_err),
      .busy       (busy),
      .psel       (psel),
      .penable    (penable),
      .pwrite     (pwrite),
      .paddr      (paddr),
      .pwdata     (pwdata),
      .prdata     (prdata),
      .pready     (pready),
      .pslverr    (pslverr)
   );

   initial begin
      pclk = 1'b0;
      forever #5 pclk = ~pclk;
   end

   task automatic tick;
      @(posedge pclk);
      #1;
   endtask

   task automatic set_req(input int i, input logic w, input logic [AW-1:0] a,
                          input logic [DW-1:0] d);
      req_write[i]         = w;
      req_addr[i*AW +: AW] = a;
      req_wdata[i*DW +: DW] = d;
   endtask

   task automatic do_reset;
      preset = 1'b1;
      tick();
      tick();
      preset = 1'b0;
   endtask

   // Advances until a response pulse appears; timed_out set if none within the budget.
   task automatic wait_resp(output logic [NR-1:0] rv, output bit timed_out);
      timed_out = 1'b1;
      rv        = '0;
      for (int n = 0; n < 40; n++) begin
         tick();
         if (resp_valid != '0) begin
            rv        = resp_valid;
            timed_out = 1'b0;
            break;
         end
      end
   endtask

   task automatic test_reset;
      req_valid = '0;
      req_write = '0;
      req_addr  = '0;
      req_wdata = '0;
      prdata    = '0;
      pready    = 1'b0;
      pslverr   = 1'b0;
      preset    = 1'b1;
      tick();
      tick();
      total++;
      if ({psel, penable, busy, resp_valid, resp_err, pwrite} !== 8'b0 || paddr !== '0 ||
          pwdata !== '0 || resp_rdata !== '0) begin
         bad++;
         $display("FAIL reset_outputs: psel=%b penable=%b busy=%b resp_valid=%b paddr=%h, want all 0",
                  psel, penable, busy, resp_valid, paddr);
      end
      preset = 1'b0;
   endtask

   task automatic test_write;
      do_reset();
      set_req(0, 1'b1, 60'h0123456789ABCDE, 32'hDEADBEEF);
      req_valid = 3'b001;
      pready    = 1'b1;
      tick();
      total++;
      if (psel !== 1'b1 || penable !== 1'b0 || busy !== 1'b1) begin
         bad++;
         $display("FAIL write_setup: psel=%b penable=%b busy=%b, want 1 0 1", psel, penable, busy);
      end
      total++;
      if (pwrite !== 1'b1 || paddr !== 60'h0123456789ABCDE || pwdata !== 32'hDEADBEEF) begin
         bad++;
         $display("FAIL write_fields: pwrite=%b paddr=%h pwdata=%h, want 1 0123456789abcde deadbeef",
                  pwrite, paddr, pwdata);
      end
      tick();
      total++;
      if (psel !== 1'b1 || penable !== 1'b1 || resp_valid !== 3'b000) begin
         bad++;
         $display("FAIL write_access: psel=%b penable=%b resp_valid=%b, want 1 1 000",
                  psel, penable, resp_valid);
      end
      tick();
      total++;
      if (resp_valid !== 3'b001 || resp_err !== 1'b0 || psel !== 1'b0 || penable !== 1'b0) begin
         bad++;
         $display("FAIL write_resp: resp_valid=%b err=%b psel=%b penable=%b, want 001 0 0 0",
                  resp_valid, resp_err, psel, penable);
      end
      req_valid = '0;
      tick();
      total++;
      if (resp_valid !== 3'b000 || busy !== 1'b0) begin
         bad++;
         $display("FAIL write_idle: resp_valid=%b busy=%b, want 000 0", resp_valid, busy);
      end
   endtask

   task automatic test_round_robin;
      logic [NR-1:0] rv;
      bit            to;
      int            order[5] = '{0, 1, 2, 0, 1};
      do_reset();
      for (int i = 0; i < NR; i++) set_req(i, 1'b1, AW'(64'h100 + i), DW'(32'hA0 + i));
      pready    = 1'b1;
      req_valid = 3'b111;
      for (int k = 0; k < 5; k++) begin
         if (k == 3) req_valid = 3'b001;
         if (k == 4) req_valid = 3'b011;
         wait_resp(rv, to);
         total++;
         if (to || rv !== NR'(1 << order[k])) begin
            bad++;
            $display("FAIL rr_grant_%0d: resp_valid=%b timed_out=%0d, want %b",
                     k, rv, to, NR'(1 << order[k]));
         end
         total++;
         if (paddr !== AW'(64'h100 + order[k])) begin
            bad++;
            $display("FAIL rr_addr_%0d: paddr=%h, want %h", k, paddr, 64'h100 + order[k]);
         end
         req_valid[order[k]] = 1'b0;
      end
      req_valid = '0;
      tick();
   endtask

   task automatic test_read_wait;
      set_req(2, 1'b0, 60'hF00D_0000_1234, 32'h0);
      pready    = 1'b0;
      pslverr   = 1'b0;
      req_valid = 3'b100;
      tick();
      total++;
      if (psel !== 1'b1 || penable !== 1'b0 || pwrite !== 1'b0) begin
         bad++;
         $display("FAIL read_setup: psel=%b penable=%b pwrite=%b, want 1 0 0", psel, penable, pwrite);
      end
      // Changing the request after grant must not disturb the transfer
      set_req(2, 1'b1, 60'h0BAD_0BAD, 32'h1);
      tick();
      for (int i = 0; i < 3; i++) begin
         total++;
         if (penable !== 1'b1 || paddr !== 60'hF00D_0000_1234 || resp_valid !== 3'b000) begin
            bad++;
            $display("FAIL read_wait_%0d: penable=%b paddr=%h resp_valid=%b, want 1 f00d00001234 000",
                     i, penable, paddr, resp_valid);
         end
         tick();
      end
      pready = 1'b1;
      prdata = 32'hCAFEF00D;
      tick();
      total++;
      if (resp_valid !== 3'b100 || resp_rdata !== 32'hCAFEF00D || resp_err !== 1'b0) begin
         bad++;
         $display("FAIL read_resp: resp_valid=%b rdata=%h err=%b, want 100 cafef00d 0",
                  resp_valid, resp_rdata, resp_err);
      end
      req_valid = '0;
      pready    = 1'b0;
      tick();
   endtask

   // hit_at < 0: pready never comes; otherwise pready rises in that ACCESS cycle (1-based)
   task automatic test_timeout(input int hit_at);
      set_req(0, 1'b0, 60'h42, 32'h0);
      prdata    = 32'h12345678;
      pready    = 1'b0;
      req_valid = 3'b001;
      tick();
      tick();
      for (int c = 1; c <= TO; c++) begin
         if (c == hit_at) pready = 1'b1;
         if (c == TO) begin
            total++;
            if (psel !== 1'b1 || penable !== 1'b1) begin
               bad++;
               $display("FAIL timeout_last_access_%0d: psel=%b penable=%b, want 1 1",
                        hit_at, psel, penable);
            end
         end
         tick();
      end
      total++;
      if (hit_at < 0) begin
         if (resp_valid !== 3'b001 || resp_err !== 1'b1 || resp_rdata !== '0 || psel !== 1'b0) begin
            bad++;
            $display("FAIL timeout_resp: resp_valid=%b err=%b rdata=%h psel=%b, want 001 1 0 0",
                     resp_valid, resp_err, resp_rdata, psel);
         end
      end else begin
         if (resp_valid !== 3'b001 || resp_err !== 1'b0 || resp_rdata !== 32'h12345678) begin
            bad++;
            $display("FAIL pready_beats_timeout: resp_valid=%b err=%b rdata=%h, want 001 0 12345678",
                     resp_valid, resp_err, resp_rdata);
         end
      end
      req_valid = '0;
      pready    = 1'b0;
      tick();
   endtask

   task automatic test_slverr;
      set_req(1, 1'b1, 60'h77, 32'h5555AAAA);
      pready    = 1'b1;
      pslverr   = 1'b1;
      req_valid = 3'b010;
      tick();
      tick();
      tick();
      total++;
      if (resp_valid !== 3'b010 || resp_err !== 1'b1) begin
         bad++;
         $display("FAIL slverr_resp: resp_valid=%b err=%b, want 010 1", resp_valid, resp_err);
      end
      req_valid = '0;
      pslverr   = 1'b0;
      pready    = 1'b0;
      tick();
   endtask

   task automatic test_reset_mid;
      logic [NR-1:0] rv;
      bit            to;
      for (int i = 0; i < NR; i++) set_req(i, 1'b0, AW'(64'h200 + i), '0);
      pready    = 1'b0;
      req_valid = 3'b111;
      tick();
      tick();
      preset = 1'b1;
      tick();
      total++;
      if (psel !== 1'b0 || penable !== 1'b0 || resp_valid !== 3'b000 || busy !== 1'b0) begin
         bad++;
         $display("FAIL reset_mid: psel=%b penable=%b resp_valid=%b busy=%b, want 0 0 000 0",
                  psel, penable, resp_valid, busy);
      end
      preset = 1'b0;
      pready = 1'b1;
      wait_resp(rv, to);
      total++;
      if (to || rv !== 3'b001 || paddr !== AW'(64'h200)) begin
         bad++;
         $display("FAIL reset_mid_regrant: resp_valid=%b paddr=%h timed_out=%0d, want 001 200",
                  rv, paddr, to);
      end
      req_valid = '0;
      tick();
   endtask

   initial begin
      total = 0;
      bad   = 0;
      test_reset();
      test_write();
      test_round_robin();
      test_read_wait();
      test_timeout(-1);
      test_timeout(TO);
      test_slverr();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
